// File: rtl/data_mem_arbiter.sv
// Round-robin CPU/debug arbiter in front of a single-port
// synchronous data memory: one access every two cycles.
module data_mem_arbiter #(
  parameter int DEPTH = 100,
  parameter int AW    = 7,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  input  logic          dbg_halt,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          addr_err,
  output logic          busy
);

  typedef enum logic {IDLE, GRANT} state_t;
  typedef enum logic {CPU, DBG} port_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          err;
  } acc_t;

  localparam int unsigned LIM = DEPTH;

  state_t        state, state_nx;
  port_t         last, win_nx, rv_port;
  acc_t          sel;
  logic          we_q, err_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          rv_q, rv_err_q;
  logic          cpu_el, dbg_el;

  assign cpu_el = cpu_req && !dbg_halt;
  assign dbg_el = dbg_req;

  always_comb begin
    state_nx = IDLE;
    win_nx   = last;
    unique case (state)
      IDLE: begin
        if (cpu_el || dbg_el) begin
          state_nx = GRANT;
          unique case (1'b1)
            (cpu_el && dbg_el):
              win_nx = (last == DBG) ? CPU : DBG;
            (cpu_el && !dbg_el):
              win_nx = CPU;
            default:
              win_nx = DBG;
          endcase
        end
      end
      GRANT: state_nx = IDLE;
    endcase
  end

  always_comb begin
    sel = '0;
    if (win_nx == CPU) begin
      sel.we    = cpu_we;
      sel.addr  = cpu_addr;
      sel.wdata = cpu_wdata;
    end else begin
      sel.we    = dbg_we;
      sel.addr  = dbg_addr;
      sel.wdata = dbg_wdata;
    end
    sel.err = 32'(sel.addr) >= LIM;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      last     <= DBG;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rv_q     <= 1'b0;
      rv_port  <= CPU;
      rv_err_q <= 1'b0;
    end else begin
      state <= state_nx;
      rv_q  <= (state == GRANT) && !we_q;
      if (state == GRANT) begin
        rv_port  <= last;
        rv_err_q <= err_q;
      end
      if (state_nx == GRANT) begin
        last    <= win_nx;
        we_q    <= sel.we;
        addr_q  <= sel.addr;
        wdata_q <= sel.wdata;
        err_q   <= sel.err;
      end
    end
  end

  assign busy      = (state == GRANT);
  assign cpu_gnt   = busy && (last == CPU);
  assign dbg_gnt   = busy && (last == DBG);
  assign mem_en    = busy && !err_q;
  assign mem_we    = busy && we_q;
  assign addr_err  = busy && err_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  // out-of-range reads return zero instead of stale memory data
  assign cpu_rvalid = rv_q && (rv_port == CPU);
  assign dbg_rvalid = rv_q && (rv_port == DBG);
  assign cpu_rdata  = (cpu_rvalid && !rv_err_q) ? mem_rdata : '0;
  assign dbg_rdata  = (dbg_rvalid && !rv_err_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomized bench for data_mem_arbiter with a transaction-level
// model, a shadow memory and directed literal scenarios.
module tb_data_mem_arbiter;

  localparam int DEPTH = 100;

  logic        clk;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [6:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_gnt, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        dbg_req, dbg_we;
  logic [6:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_gnt, dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic        dbg_halt;
  logic        mem_en, mem_we;
  logic [6:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        addr_err, busy;

  int errors = 0;
  int checks = 0;

  data_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
    .dbg_rdata(dbg_rdata),
    .dbg_halt(dbg_halt),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .addr_err(addr_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(int i);
    if (i == 5) return 32'h1234;
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A;
  endfunction

  // physical memory seen by the DUT
  logic [31:0] ram [128];
  initial begin
    for (int i = 0; i < 128; i++) ram[i] = init_word(i);
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      if (mem_en) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        else mem_rdata <= ram[mem_addr];
      end
    end
  end

  // transaction-level model of the arbiter
  logic [31:0] shadow [128];
  bit          g_act = 0, g_port = 0, g_we = 0, g_err = 0;
  logic [6:0]  g_a;
  logic [31:0] g_d, g_rd;
  bit          rv_act = 0, rv_port = 0;
  logic [31:0] rv_data = '0;
  bit          last = 1;
  logic [6:0]  e_addr = '0;
  logic [31:0] e_wdata = '0;
  int          ncyc = 0;

  initial begin
    bit ce;
    for (int i = 0; i < 128; i++) shadow[i] = init_word(i);
    forever begin
      @(posedge clk);
      ncyc++;
      if (reset) begin
        g_act   = 0;
        rv_act  = 0;
        last    = 1;
        e_addr  = '0;
        e_wdata = '0;
      end else begin
        rv_act  = g_act && !g_we;
        rv_port = g_port;
        rv_data = g_err ? 32'h0 : g_rd;
        ce = cpu_req && !dbg_halt;
        if (g_act) begin
          g_act = 0;
        end else if (ce || dbg_req) begin
          g_port = (ce && dbg_req) ? !last : !ce;
          g_we  = g_port ? dbg_we : cpu_we;
          g_a   = g_port ? dbg_addr : cpu_addr;
          g_d   = g_port ? dbg_wdata : cpu_wdata;
          g_err = int'(g_a) >= DEPTH;
          g_rd  = shadow[g_a];
          if (g_we && !g_err) shadow[g_a] = g_d;
          e_addr  = g_a;
          e_wdata = g_d;
          last    = g_port;
          g_act   = 1;
        end
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h",
               nm, $time, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ncyc > 0) begin
        chk("cpu_gnt", cpu_gnt, g_act && !g_port);
        chk("dbg_gnt", dbg_gnt, g_act && g_port);
        chk("mem_en", mem_en, g_act && !g_err);
        chk("mem_we", mem_we, g_act && g_we);
        chk("addr_err", addr_err, g_act && g_err);
        chk("busy", busy, g_act);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wdata);
        chk("cpu_rvalid", cpu_rvalid, rv_act && !rv_port);
        chk("cpu_rdata", cpu_rdata,
            (rv_act && !rv_port) ? rv_data : 32'h0);
        chk("dbg_rvalid", dbg_rvalid, rv_act && rv_port);
        chk("dbg_rdata", dbg_rdata,
            (rv_act && rv_port) ? rv_data : 32'h0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    cpu_req  = 1'b0;
    dbg_req  = 1'b0;
    dbg_halt = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  function automatic logic [6:0] rnd_addr();
    case ($urandom_range(3))
      0: return 7'd99;
      1: return 7'd100;
      2: return 7'($urandom_range(127));
      default: return 7'($urandom_range(7));
    endcase
  endfunction

  initial begin
    logic eg_c, eg_d;
    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    dbg_halt = 0;

    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);

    // single CPU read of word 5
    cpu_req = 1; cpu_we = 0; cpu_addr = 7'd5;
    step();
    chk("t1_gnt", cpu_gnt, 1);
    chk("t1_en", mem_en, 1);
    chk("t1_we", mem_we, 0);
    chk("t1_addr", mem_addr, 5);
    cpu_req = 0;
    step();
    chk("t1_rvalid", cpu_rvalid, 1);
    chk("t1_rdata", cpu_rdata, 32'h1234);

    // both held high: CPU, DBG, CPU, DBG
    do_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 7'd1;
    dbg_req = 1; dbg_we = 0; dbg_addr = 7'd2;
    for (int c = 1; c <= 8; c++) begin
      step();
      eg_c = (c == 1 || c == 5);
      eg_d = (c == 3 || c == 7);
      chk("t2_cpu_gnt", cpu_gnt, eg_c);
      chk("t2_dbg_gnt", dbg_gnt, eg_d);
    end
    cpu_req = 0; dbg_req = 0;
    step(); step();

    // DBG write 99, CPU reads it back, DBG write 100
    do_reset();
    dbg_req = 1; dbg_we = 1; dbg_addr = 7'd99;
    dbg_wdata = 32'hCAFE;
    step();
    chk("t3_dbg_gnt", dbg_gnt, 1);
    chk("t3_we", mem_we, 1);
    chk("t3_en", mem_en, 1);
    dbg_req = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 7'd99;
    step();
    step();
    chk("t3_cpu_gnt", cpu_gnt, 1);
    cpu_req = 0;
    step();
    chk("t3_rvalid", cpu_rvalid, 1);
    chk("t3_rdata", cpu_rdata, 32'hCAFE);
    dbg_req = 1; dbg_we = 1; dbg_addr = 7'd100;
    step();
    chk("t3_err_gnt", dbg_gnt, 1);
    chk("t3_err", addr_err, 1);
    chk("t3_err_en", mem_en, 0);
    dbg_req = 0;
    step();

    // halt blocks the CPU, DBG still served
    do_reset();
    dbg_halt = 1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 7'd2;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("t4_cpu_gnt", cpu_gnt, 0);
    end
    dbg_req = 1; dbg_we = 0; dbg_addr = 7'd3;
    step();
    chk("t4_dbg_gnt", dbg_gnt, 1);
    dbg_req = 0;
    step();
    chk("t4_dbg_rvalid", dbg_rvalid, 1);
    dbg_halt = 0;
    step();
    chk("t4_cpu_late", cpu_gnt, 1);
    cpu_req = 0;
    step(); step();

    // out-of-range CPU read returns zero
    do_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 7'd100;
    step();
    chk("t5_gnt", cpu_gnt, 1);
    chk("t5_err", addr_err, 1);
    chk("t5_en", mem_en, 0);
    cpu_req = 0;
    step();
    chk("t5_rvalid", cpu_rvalid, 1);
    chk("t5_rdata", cpu_rdata, 0);

    // reset during GRANT aborts the read
    do_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 7'd7;
    step();
    chk("t6_gnt", cpu_gnt, 1);
    reset = 1; cpu_req = 0;
    step();
    chk("t6_rvalid", cpu_rvalid, 0);
    chk("t6_gnt_off", cpu_gnt, 0);
    chk("t6_busy", busy, 0);
    chk("t6_addr", mem_addr, 0);
    chk("t6_rdata", cpu_rdata, 0);
    reset = 0;
    step();
    chk("t6_rvalid2", cpu_rvalid, 0);
    cpu_req = 1; cpu_addr = 7'd4;
    dbg_req = 1; dbg_we = 0; dbg_addr = 7'd6;
    step();
    chk("t6_tie_cpu", cpu_gnt, 1);
    chk("t6_tie_dbg", dbg_gnt, 0);
    cpu_req = 0; dbg_req = 0;
    step(); step();

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      step();
      if (reset) reset = 0;
      else if ($urandom_range(199) == 0) reset = 1;
      if (cpu_gnt || !cpu_req) begin
        cpu_req   = ($urandom_range(2) != 0);
        cpu_we    = 1'($urandom_range(1));
        cpu_addr  = rnd_addr();
        cpu_wdata = $urandom;
      end
      if (dbg_gnt || !dbg_req) begin
        dbg_req   = ($urandom_range(2) != 0);
        dbg_we    = 1'($urandom_range(1));
        dbg_addr  = rnd_addr();
        dbg_wdata = $urandom;
      end
      if ($urandom_range(15) == 0) dbg_halt = !dbg_halt;
    end
    reset = 0; cpu_req = 0; dbg_req = 0; dbg_halt = 0;
    step(); step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
